// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the 4-in / 4-out FIFO round-robin scheduler.
package fifo_sched_pkg;

  localparam int N_PORTS  = 4;
  localparam int DATA_W_DEF = 6;
  localparam int DEST_HI  = DATA_W_DEF - 1;
  localparam int DEST_LO  = DATA_W_DEF - 2;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } sched_state_t;

  // A pop issued last cycle whose word arrives on in_data this cycle.
  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } pend_t;

  function automatic logic [N_PORTS-1:0] onehot4(input logic [1:0] idx);
    logic [N_PORTS-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin arbiter: searches ptr+1, ptr+2, ptr+3, ptr
// over the unmasked requests and returns a one-hot grant.
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic [1:0] ptr,
  input  logic       en,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       valid
);

  logic [3:0] cand;
  logic [1:0] p;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    cand    = req & ~mask;
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    p       = '0;
    if (en) begin
      for (int k = 1; k <= 4; k++) begin
        p = ptr + 2'(k);
        if (!valid && cand[p]) begin
          valid   = 1'b1;
          gnt_idx = p;
          gnt     = 4'b0001 << p;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin scheduler popping 4 input FIFOs and routing each word to the
// output FIFO named by its destination field; thresholds loaded in INIT.
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int UMB_W      = 3,
  parameter int UMB_LL_DEF = 3,
  parameter int UMB_VA_DEF = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [UMB_W-1:0]      umbral_ll_cfg,
  input  logic [UMB_W-1:0]      umbral_va_cfg,
  input  logic [3:0]            in_empty,
  input  logic [4*DATA_W-1:0]   in_data,
  input  logic [3:0]            out_afull,
  input  logic [7:0]            fifo_err,
  output logic [3:0]            in_rd,
  output logic [3:0]            out_wr,
  output logic [DATA_W-1:0]     out_data,
  output logic [UMB_W-1:0]      umbral_lleno,
  output logic [UMB_W-1:0]      umbral_vacio,
  output logic [1:0]            state,
  output logic                  idle
);

  sched_state_t      state_q, state_d;
  logic [1:0]        ptr_q;
  pend_t             pend_q;
  logic [UMB_W-1:0]  ll_q, va_q;

  logic              any_err, any_req, arb_en, gnt_valid;
  logic [3:0]        gnt, mask;
  logic [1:0]        gnt_idx;
  logic [DATA_W-1:0] word;

  assign any_err = |fifo_err;
  assign any_req = ~&in_empty;
  // Grants stop on error, on a pending re-init, and on any output backpressure.
  assign arb_en  = (state_q == ST_ACTIVE) && !any_err && !init && !(|out_afull);
  // in_empty lags a pop by one cycle, so last cycle's port cannot be trusted yet.
  assign mask    = pend_q.valid ? onehot4(pend_q.idx) : 4'b0000;

  rr_arb4 u_arb (
    .req     (~in_empty),
    .mask    (mask),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .valid   (gnt_valid)
  );

  assign in_rd    = gnt;
  assign word     = in_data[int'(pend_q.idx)*DATA_W +: DATA_W];
  assign out_data = pend_q.valid ? word : '0;
  assign out_wr   = pend_q.valid ? onehot4(word[DEST_HI:DEST_LO]) : 4'b0000;

  assign state        = state_q;
  assign idle         = (state_q == ST_IDLE);
  assign umbral_lleno = ll_q;
  assign umbral_vacio = va_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init)         state_d = ST_INIT;
        else if (any_err) state_d = ST_ERROR;
        else if (any_req) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (any_err)                       state_d = ST_ERROR;
        else if (init) begin
          if (!pend_q.valid)               state_d = ST_INIT;
        end
        else if (!any_req && !pend_q.valid) state_d = ST_IDLE;
      end
      ST_ERROR:  if (init) state_d = ST_INIT;
      default:   state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!reset) begin
      state_q <= ST_INIT;
      ptr_q   <= 2'd3;
      pend_q  <= '0;
      ll_q    <= UMB_W'(UMB_LL_DEF);
      va_q    <= UMB_W'(UMB_VA_DEF);
    end else begin
      state_q <= state_d;
      pend_q  <= '{valid: gnt_valid, idx: gnt_idx};
      if (gnt_valid) ptr_q <= gnt_idx;
      if (state_q == ST_INIT) begin
        ll_q <= umbral_ll_cfg;
        va_q <= umbral_va_cfg;
      end
    end
  end

endmodule
